// File: rtl/br_cmp_pipe.sv
// Two-stage pipelined RV32I branch comparator with valid/ready handshakes and mispredict detection.
// Optional saturating statistics counters are compiled in when BR_CMP_STATS_EN is defined.
module br_cmp_pipe #(
    parameter int WIDTH  = 32,
    parameter int TAG_W  = 4,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_cmpop,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic              in_pred_taken,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_br_en,
    output logic              out_mispredict,
    output logic              out_illegal,
    output logic [TAG_W-1:0]  out_tag
`ifdef BR_CMP_STATS_EN
    ,
    input  logic              stat_clear,
    output logic [STAT_W-1:0] stat_br,
    output logic [STAT_W-1:0] stat_taken,
    output logic [STAT_W-1:0] stat_mispred
`endif
);

    // Returns {illegal, br_en}; reserved funct3 codes never take the branch.
    function automatic logic [1:0] f_resolve(input logic [2:0] op,
                                             input logic signed [WIDTH-1:0] a,
                                             input logic signed [WIDTH-1:0] b);
        logic br;
        logic ill;
        br  = 1'b0;
        ill = 1'b0;
        case (op)
            3'b000:  br = (a == b);
            3'b001:  br = (a != b);
            3'b100:  br = (a < b);
            3'b101:  br = !(a < b);
            3'b110:  br = ($unsigned(a) < $unsigned(b));
            3'b111:  br = !($unsigned(a) < $unsigned(b));
            default: ill = 1'b1;
        endcase
        return {ill, br};
    endfunction

    logic                     r_vld_p1;
    logic [2:0]               r_op_p1;
    logic signed [WIDTH-1:0]  r_a_p1;
    logic signed [WIDTH-1:0]  r_b_p1;
    logic                     r_pred_p1;
    logic [TAG_W-1:0]         r_tag_p1;

    logic                     r_vld_p2;
    logic                     r_br_en_p2;
    logic                     r_mis_p2;
    logic                     r_ill_p2;
    logic [TAG_W-1:0]         r_tag_p2;

    logic                     w_s2_load;
    logic                     w_accept;
    logic [1:0]               w_res_p1;
    logic                     w_mis_p1;

    assign w_s2_load = !r_vld_p2 || out_ready;
    assign in_ready  = !r_vld_p1 || w_s2_load;
    assign w_accept  = in_valid && in_ready;

    assign w_res_p1  = f_resolve(r_op_p1, r_a_p1, r_b_p1);
    assign w_mis_p1  = !w_res_p1[1] && (w_res_p1[0] != r_pred_p1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else if (flush) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            if (in_ready) begin
                r_vld_p1 <= in_valid;
            end
            if (w_s2_load) begin
                r_vld_p2 <= r_vld_p1;
            end
        end
    end

    // S1: capture operands on accept
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op_p1   <= in_cmpop;
            r_a_p1    <= in_a;
            r_b_p1    <= in_b;
            r_pred_p1 <= in_pred_taken;
            r_tag_p1  <= in_tag;
        end
    end

    // S2: resolved result, held stable while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_en_p2 <= 1'b0;
            r_mis_p2   <= 1'b0;
            r_ill_p2   <= 1'b0;
            r_tag_p2   <= '0;
        end else if (w_s2_load && r_vld_p1) begin
            r_br_en_p2 <= w_res_p1[0];
            r_mis_p2   <= w_mis_p1;
            r_ill_p2   <= w_res_p1[1];
            r_tag_p2   <= r_tag_p1;
        end
    end

    assign out_valid      = r_vld_p2;
    assign out_br_en      = r_br_en_p2;
    assign out_mispredict = r_mis_p2;
    assign out_illegal    = r_ill_p2;
    assign out_tag        = r_tag_p2;

`ifdef BR_CMP_STATS_EN
    function automatic logic [STAT_W-1:0] f_sat_inc(input logic [STAT_W-1:0] cnt,
                                                    input logic en);
        if (!en || (cnt == {STAT_W{1'b1}})) begin
            return cnt;
        end
        return cnt + {{(STAT_W-1){1'b0}}, 1'b1};
    endfunction

    logic              w_deliver;
    logic [STAT_W-1:0] r_stat_br;
    logic [STAT_W-1:0] r_stat_taken;
    logic [STAT_W-1:0] r_stat_mis;

    assign w_deliver = r_vld_p2 && out_ready;

    always_ff @(posedge clk) begin
        if (rst || stat_clear) begin
            r_stat_br    <= '0;
            r_stat_taken <= '0;
            r_stat_mis   <= '0;
        end else if (w_deliver) begin
            r_stat_br    <= f_sat_inc(r_stat_br, !r_ill_p2);
            r_stat_taken <= f_sat_inc(r_stat_taken, r_br_en_p2);
            r_stat_mis   <= f_sat_inc(r_stat_mis, r_mis_p2);
        end
    end

    assign stat_br      = r_stat_br;
    assign stat_taken   = r_stat_taken;
    assign stat_mispred = r_stat_mis;
`endif

endmodule

// File: tb/tb_br_cmp_pipe.sv
// Scoreboard bench for br_cmp_pipe: table vectors, stall, flush, reset and random traffic.
// Statistics checks run when BR_CMP_STATS_EN is defined.
module tb_br_cmp_pipe;
    localparam int WIDTH  = 32;
    localparam int TAG_W  = 4;
    localparam int STAT_W = 2;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready, in_pred_taken;
    logic [2:0]        in_cmpop;
    logic [WIDTH-1:0]  in_a, in_b;
    logic [TAG_W-1:0]  in_tag, out_tag;
    logic              out_valid, out_ready, out_br_en, out_mispredict, out_illegal;
`ifdef BR_CMP_STATS_EN
    logic              stat_clear;
    logic [STAT_W-1:0] stat_br, stat_taken, stat_mispred;
`endif

    always #5 clk = ~clk;

    br_cmp_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_cmpop(in_cmpop),
        .in_a(in_a), .in_b(in_b), .in_pred_taken(in_pred_taken), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_br_en(out_br_en),
        .out_mispredict(out_mispredict), .out_illegal(out_illegal), .out_tag(out_tag)
`ifdef BR_CMP_STATS_EN
        , .stat_clear(stat_clear), .stat_br(stat_br), .stat_taken(stat_taken),
        .stat_mispred(stat_mispred)
`endif
    );

    typedef struct {
        logic br; logic mis; logic ill; logic [TAG_W-1:0] tag; int acc;
    } exp_t;

    typedef struct {
        logic [2:0] op; logic [31:0] a; logic [31:0] b; logic pred; logic [3:0] tag;
        logic br; logic mis; logic ill;
    } vec_t;

    exp_t q[$];
    exp_t pend;
    int   checks = 0;
    int   errors = 0;
    int   cyc_n = 0;
    bit   chk_lat = 1'b0;
    bit   acc_flag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Independent reference: signed order derived from sign bits, not a signed compare.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic pred,
                                   input logic [3:0] tag);
        exp_t e;
        logic slt;
        slt   = (a[31] != b[31]) ? a[31] : (a < b);
        e.ill = (op == 3'b010) || (op == 3'b011);
        case (op)
            3'b000:  e.br = (a == b);
            3'b001:  e.br = (a != b);
            3'b100:  e.br = slt;
            3'b101:  e.br = !slt;
            3'b110:  e.br = (a < b);
            3'b111:  e.br = (a >= b);
            default: e.br = 1'b0;
        endcase
        e.mis = e.ill ? 1'b0 : (e.br ^ pred);
        e.tag = tag;
        e.acc = 0;
        return e;
    endfunction

    task automatic drive_vec(input vec_t v);
        in_valid = 1'b1; in_cmpop = v.op; in_a = v.a; in_b = v.b;
        in_pred_taken = v.pred; in_tag = v.tag;
        pend.br = v.br; pend.mis = v.mis; pend.ill = v.ill; pend.tag = v.tag;
    endtask

    task automatic drive_rand(input logic [3:0] tag);
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        p;
        op = 3'($urandom_range(0, 7));
        a  = $urandom;
        b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
        p  = 1'($urandom_range(0, 1));
        in_valid = 1'b1; in_cmpop = op; in_a = a; in_b = b; in_pred_taken = p; in_tag = tag;
        pend = model(op, a, b, p, tag);
    endtask

    // One clock: observe delivery and acceptance at the falling edge, return at posedge+1.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out tag=%0d required=none", out_tag);
            end else begin
                e = q.pop_front();
                check("out_tag", 32'(out_tag), 32'(e.tag));
                check("out_br_en", 32'(out_br_en), 32'(e.br));
                check("out_mispredict", 32'(out_mispredict), 32'(e.mis));
                check("out_illegal", 32'(out_illegal), 32'(e.ill));
                if (chk_lat) check("latency", 32'(cyc_n - e.acc), 32'd2);
            end
        end
        acc_flag = in_valid && in_ready && !rst && !flush;
        if (rst || flush) q.delete();
        else if (acc_flag) begin
            e = pend;
            e.acc = cyc_n;
            q.push_back(e);
        end
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    vec_t vt[12];
    vec_t sv[3];
    vec_t fv;

    initial begin
        int k;
        bit have, unstable;
        logic [TAG_W+2:0] snap;

        vt[0]  = '{3'b100, 32'hFFFFFFFF, 32'h1,        1'b1, 4'd1,  1'b1, 1'b0, 1'b0};
        vt[1]  = '{3'b110, 32'hFFFFFFFF, 32'h1,        1'b0, 4'd2,  1'b0, 1'b0, 1'b0};
        vt[2]  = '{3'b000, 32'h5,        32'h5,        1'b1, 4'd3,  1'b1, 1'b0, 1'b0};
        vt[3]  = '{3'b101, 32'h80000000, 32'h0,        1'b1, 4'd4,  1'b0, 1'b1, 1'b0};
        vt[4]  = '{3'b001, 32'h3,        32'h3,        1'b1, 4'd5,  1'b0, 1'b1, 1'b0};
        vt[5]  = '{3'b010, 32'h3,        32'h3,        1'b1, 4'd6,  1'b0, 1'b0, 1'b1};
        vt[6]  = '{3'b011, 32'h1,        32'h1,        1'b0, 4'd7,  1'b0, 1'b0, 1'b1};
        vt[7]  = '{3'b111, 32'h0,        32'hFFFFFFFF, 1'b0, 4'd8,  1'b0, 1'b0, 1'b0};
        vt[8]  = '{3'b111, 32'hFFFFFFFF, 32'h0,        1'b1, 4'd9,  1'b1, 1'b0, 1'b0};
        vt[9]  = '{3'b100, 32'h7FFFFFFF, 32'h80000000, 1'b0, 4'd10, 1'b0, 1'b0, 1'b0};
        vt[10] = '{3'b001, 32'h10,       32'h11,       1'b0, 4'd11, 1'b1, 1'b1, 1'b0};
        vt[11] = '{3'b101, 32'h5,        32'h5,        1'b1, 4'd12, 1'b1, 1'b0, 1'b0};
        sv[0]  = '{3'b000, 32'h1,        32'h1,        1'b1, 4'd1,  1'b1, 1'b0, 1'b0};
        sv[1]  = '{3'b110, 32'h2,        32'h9,        1'b0, 4'd2,  1'b1, 1'b1, 1'b0};
        sv[2]  = '{3'b100, 32'h9,        32'hFFFFFFF0, 1'b1, 4'd3,  1'b0, 1'b1, 1'b0};
        fv     = '{3'b000, 32'h0,        32'h0,        1'b1, 4'd0,  1'b1, 1'b0, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_cmpop = '0; in_a = '0; in_b = '0;
        in_pred_taken = 1'b0; in_tag = '0; out_ready = 1'b1;
`ifdef BR_CMP_STATS_EN
        stat_clear = 1'b0;
`endif
        @(posedge clk); #1;
        step(); step();
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_br_en", 32'(out_br_en), 32'd0);
        check("rst_mispredict", 32'(out_mispredict), 32'd0);
        check("rst_illegal", 32'(out_illegal), 32'd0);
        check("rst_tag", 32'(out_tag), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef BR_CMP_STATS_EN
        check("rst_stat_br", 32'(stat_br), 32'd0);
`endif

        // Back-to-back table vectors with latency check
        chk_lat = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive_vec(vt[i]);
            check("b2b_in_ready", 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk_lat = 1'b0;
        check("b2b_drained", 32'(q.size()), 32'd0);

        // Stall with three ops offered
        out_ready = 1'b0;
        k = 0; have = 1'b0; unstable = 1'b0; snap = '0;
        for (int i = 0; i < 5; i++) begin
            drive_vec(sv[k]);
            step();
            if (acc_flag) k++;
            if (out_valid) begin
                if (!have) begin
                    have = 1'b1;
                    snap = {out_br_en, out_mispredict, out_illegal, out_tag};
                end else if (snap != {out_br_en, out_mispredict, out_illegal, out_tag}) begin
                    unstable = 1'b1;
                end
            end
        end
        check("stall_accepts", 32'(k), 32'd2);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_stable", 32'(unstable), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 10 && k < 3; i++) begin
            drive_vec(sv[k]);
            step();
            if (acc_flag) k++;
        end
        in_valid = 1'b0;
        check("stall_third_accepted", 32'(k), 32'd3);
        for (int i = 0; i < 4; i++) step();
        check("stall_drained", 32'(q.size()), 32'd0);

        // Flush with both stages full and output stalled
        out_ready = 1'b0;
        fv.tag = 4'd8;  drive_vec(fv); step();
        fv.tag = 4'd9;  drive_vec(fv); step();
        check("flush_full_valid", 32'(out_valid), 32'd1);
        check("flush_full_in_ready", 32'(in_ready), 32'd0);
        flush = 1'b1; fv.tag = 4'd10; drive_vec(fv); step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Flush while delivering: the delivered result still counts, S1 and the new op die
        fv.tag = 4'd11; drive_vec(fv); step();
        fv.tag = 4'd12; drive_vec(fv); step();
        flush = 1'b1; fv.tag = 4'd13; drive_vec(fv);
        check("flush2_in_ready", 32'(in_ready), 32'd1);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush2_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) step();
        check("flush_drained", 32'(q.size()), 32'd0);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) begin
            drive_rand(4'(i + 1));
            step();
        end
        rst = 1'b1; drive_rand(4'd4); step();
        rst = 1'b0; in_valid = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_tag", 32'(out_tag), 32'd0);

        // Random traffic with random backpressure
        for (int i = 0; i < 60; i++) begin
            out_ready = 1'($urandom_range(0, 3) != 0);
            if (!in_valid || acc_flag) begin
                if ($urandom_range(0, 4) != 0) drive_rand(4'($urandom));
                else in_valid = 1'b0;
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("rand_drained", 32'(q.size()), 32'd0);

`ifdef BR_CMP_STATS_EN
        stat_clear = 1'b1; step(); stat_clear = 1'b0;
        check("stat_pre_clear", 32'(stat_br), 32'd0);
        for (int i = 0; i < 5; i++) begin
            fv.tag = 4'(i); drive_vec(fv); step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("stat_br_sat", 32'(stat_br), 32'd3);
        check("stat_taken_sat", 32'(stat_taken), 32'd3);
        check("stat_mispred", 32'(stat_mispred), 32'd0);
        stat_clear = 1'b1; step(); stat_clear = 1'b0;
        check("stat_clr_br", 32'(stat_br), 32'd0);
        check("stat_clr_taken", 32'(stat_taken), 32'd0);
        check("stat_clr_mispred", 32'(stat_mispred), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
